// File: rtl/regfile_hilo.sv
// Architectural register file with two combinational read ports, one clocked
// write-back port, and the HI/LO multiply/move register pair. Both the GPR
// read ports and the HI/LO outputs forward same-cycle write data so the
// decode stage never sees a stale WB result.
module regfile_hilo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // GPR write-back; reset clears the whole array and drops any coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // HI/LO always update as a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Read port 1: enable is tested first so an undriven address with re1=0
  // cannot leak into the output.
  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  // Read port 2: identical structure to port 1, fully independent.
  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

  // HI/LO outputs with same-cycle forwarding of the WB values.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = hilo_we ? hi_i : hi_q;
      lo_o = hilo_we ? lo_i : lo_q;
    end
  end

endmodule

// File: doc/regfile_hilo.md
Name: regfile_hilo

Overview:
- Architectural register file that serves the decode stage's two operand read requests (read enable + address per port).
- Takes the single write-back port from the WB pipeline stage.
- Also holds the HI/LO multiply/move registers, which are read by MFHI/MFLO and written by MTHI/MTLO/MUL at write-back.
- Read ports are combinational so decode gets operands in the same cycle it issues addresses. Writes are clocked.

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of GPRs; register 0 is hardwired to zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1).
- we  in  1  GPR write enable from WB.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- re1  in  1  read enable, port 1 (decode reg1_read).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.
- hilo_we  in  1  HI/LO write enable from WB.
- hi_i  in  DATA_W  HI write data.
- lo_i  in  DATA_W  LO write data.
- hi_o  out  DATA_W  current HI value (bypassed).
- lo_o  out  DATA_W  current LO value (bypassed).

Behaviour:
- Storage: NUM_REGS x DATA_W GPR array, plus separate HI and LO registers.
- Reset, clocked when rst=1 at a rising edge:
  - Every GPR, HI and LO is cleared to 0 in that single edge.
  - Any write presented in the same cycle is discarded.
- Reset, combinational view while rst=1: rdata1, rdata2, hi_o and lo_o are all driven 0.
- GPR write:
  - At the rising edge with rst=0, we=1 and waddr!=0: reg[waddr] <= wdata.
  - Writes to address 0 are ignored; reg[0] always reads 0.
  - Write latency is 1 cycle. The value is visible through the array from the next cycle, and in the same cycle via bypass.
- GPR read port n, evaluated combinationally in priority order:
  1. rst=1 -> 0.
  2. raddrn==0 -> 0, regardless of any write to address 0.
  3. ren=1, we=1 and waddr==raddrn -> wdata (write-through bypass; closes the WB->ID hazard).
  4. ren=1 -> reg[raddrn].
  5. ren=0 -> 0.
- Both read ports are independent. Both may hit the same address, including the bypassed one, in the same cycle and return identical data.
- HI/LO write: at the rising edge with rst=0 and hilo_we=1, HI <= hi_i and LO <= lo_i. Both always update together; there is no partial write.
- HI/LO read: hi_o = hilo_we ? hi_i : HI, and lo_o likewise (same-cycle bypass). Both are 0 while rst=1.
- There is no handshake and no stall output. The block always accepts one GPR write and one HI/LO write per cycle.
- Reset mid-stream: a write coincident with rst=1 is lost. The first post-reset read of any register returns 0.
- Undefined/X on raddr with ren=0 must not propagate: the output is 0.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to r5 and hilo_we with hi=0x1, lo=0x2, then assert rst for 1 cycle.
  - Required: rdata1 for r5 = 0, hi_o = 0, lo_o = 0. During the rst cycle, all outputs = 0.
- Basic write/read:
  - Write r7=0x12345678; next cycle re1=1, raddr1=7.
  - Required: rdata1 = 0x12345678. With re1=0, rdata1 = 0.
- Zero register:
  - we=1, waddr=0, wdata=0xFFFFFFFF, with re1=1, raddr1=0 in the same and the next cycle.
  - Required: rdata1 = 0 in both cycles.
- Bypass:
  - r3 holds 0xAAAA0000. Same cycle: we=1, waddr=3, wdata=0x5555; re1=re2=1, raddr1=raddr2=3.
  - Required: rdata1 = rdata2 = 0x5555. The following cycle with we=0 still reads 0x5555.
- Dual-port independence:
  - r1=0x11, r2=0x22; raddr1=1, raddr2=2, while writing r9=0x99.
  - Required: rdata1 = 0x11, rdata2 = 0x22, unaffected by the r9 write.
- HI/LO:
  - hilo_we=1, hi_i=0xCAFE, lo_i=0xBEEF.
  - Required: hi_o = 0xCAFE and lo_o = 0xBEEF in the same cycle (bypass), holding after hilo_we drops.
  - Then hilo_we=1, hi_i=0, lo_i=7 -> hi_o = 0, lo_o = 7.
